// File: rtl/fetch_pkg.sv
// Shared types for the line-fill fetch engine: request opcodes and FSM states.
package fetch_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_FILL  = 2'b01,
    CMD_INVAL = 2'b10,
    CMD_RSVD  = 2'b11
  } fetch_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_engine.sv
// Single-outstanding fetch engine: bursts one line from the bus into a line-buffer
// slot (FILL) or retires a slot without bus traffic (INVAL).
module fetch_engine
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32,
  localparam int TW = $clog2(LIST_DEPTH),
  localparam int BW = $clog2(LIST_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [1:0]            fetch_cmd,
  input  logic [TW-1:0]         fetch_tag,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_done,
  output logic [TW-1:0]         done_tag,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_gnt,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_rvalid,
  output logic                  mem_wen,
  output logic [TW+BW-1:0]      mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [BW-1:0]         LAST_BEAT = BW'(LIST_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LIST_WIDTH - 1);

  fetch_state_e          state_q, state_d;
  logic [BW-1:0]         beat_q,  beat_d;
  logic [TW-1:0]         tag_q,   tag_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  fetch_cmd_e            cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      tag_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tag_d      = tag_q;
    base_d     = base_q;
    fetch_gnt  = 1'b0;
    fetch_done = 1'b0;
    done_tag   = '0;
    bus_req    = 1'b0;
    bus_addr   = '0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    cmd        = fetch_cmd_e'(fetch_cmd);

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          fetch_gnt = 1'b1;
          case (cmd)
            CMD_FILL: begin
              tag_d   = fetch_tag;
              base_d  = fetch_addr & ~LINE_MASK;
              state_d = ST_REQ;
            end
            CMD_INVAL: begin
              tag_d   = fetch_tag;
              state_d = ST_DONE;
            end
            default: ;
          endcase
        end
      end
      ST_REQ: begin
        bus_req  = 1'b1;
        bus_addr = base_q;
        if (bus_gnt) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus_rvalid) begin
          mem_wen   = 1'b1;
          mem_waddr = {tag_q, beat_q};
          mem_wdata = bus_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_DONE: begin
        fetch_done = 1'b1;
        done_tag   = tag_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are combinational from state and inputs, so they are forced quiet
    // for the whole reset cycle, before the registers have actually cleared.
    if (rst) begin
      fetch_gnt  = 1'b0;
      fetch_done = 1'b0;
      done_tag   = '0;
      bus_req    = 1'b0;
      bus_addr   = '0;
      mem_wen    = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
    end
  end

endmodule

// File: tb/tb_fetch_engine.sv
// Scoreboard bench for fetch_engine: expected line writes and completions are queued
// when a request is issued and popped as the engine produces them.
module tb_fetch_engine;
  import fetch_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LD = 4;
  localparam int LW = 32;
  localparam int TW = 2;
  localparam int BW = 5;

  typedef logic [TW+BW+DW-1:0] wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [1:0]    fetch_cmd;
  logic [TW-1:0] fetch_tag;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_done;
  logic [TW-1:0] done_tag;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic          bus_gnt;
  logic [DW-1:0] bus_rdata;
  logic          bus_rvalid;
  logic          mem_wen;
  logic [TW+BW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  int n_cmp = 0;
  int n_err = 0;
  wr_t           exp_wr[$];
  logic [TW-1:0] exp_done[$];

  fetch_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LIST_DEPTH(LD),
    .LIST_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag),
    .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .done_tag(done_tag), .bus_req(bus_req), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_cmd  = CMD_NOP;
    fetch_tag  = '0;
    fetch_addr = '0;
    bus_gnt    = 1'b0;
    bus_rdata  = '0;
    bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_req = 1'b1; fetch_cmd = CMD_FILL; fetch_tag = 2'd3; fetch_addr = 32'hFFFF_FFFF;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({fetch_gnt, fetch_done, done_tag, bus_req, bus_addr, mem_wen, mem_waddr, mem_wdata} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got gnt=%b done=%b tag=%h breq=%b baddr=%h wen=%b waddr=%h wdata=%h, required all 0",
                 fetch_gnt, fetch_done, done_tag, bus_req, bus_addr, mem_wen, mem_waddr, mem_wdata);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({fetch_gnt, fetch_done, bus_req, mem_wen} !== 4'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got gnt=%b done=%b breq=%b wen=%b, required 0000",
               fetch_gnt, fetch_done, bus_req, mem_wen);
    end
    tick();
  endtask

  // Queues the whole line plus its completion, raises the request and checks the grant.
  task automatic issue_fill(input logic [TW-1:0] tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] seed);
    for (int i = 0; i < LW; i++) exp_wr.push_back({tag, BW'(i), seed + DW'(i)});
    exp_done.push_back(tag);
    fetch_req = 1'b1; fetch_cmd = CMD_FILL; fetch_tag = tag; fetch_addr = addr;
    @(negedge clk);
    n_cmp++;
    if (fetch_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL fill_gnt: got fetch_gnt=%b, required 1", fetch_gnt);
    end
  endtask

  task automatic run_fill(input logic [TW-1:0] tag, input logic [AW-1:0] addr,
                          input logic [DW-1:0] seed, input int wait_cyc, input int gap,
                          input bit hold);
    logic [AW-1:0] base;
    wr_t e;
    base = addr & ~AW'(LW - 1);
    for (int w = 0; w <= wait_cyc; w++) begin
      bus_gnt = (w == wait_cyc);
      @(negedge clk);
      n_cmp++;
      if (bus_req !== 1'b1 || bus_addr !== base) begin
        n_err++;
        $display("FAIL bus_request: got bus_req=%b bus_addr=%h, required 1 / %h", bus_req, bus_addr, base);
      end
      if (hold) begin
        n_cmp++;
        if (fetch_gnt !== 1'b0) begin
          n_err++;
          $display("FAIL busy_gnt_req: got fetch_gnt=%b, required 0", fetch_gnt);
        end
      end
      tick();
    end
    bus_gnt = 1'b0;
    for (int i = 0; i < LW; i++) begin
      for (int g = 0; g <= gap; g++) begin
        bus_rvalid = (g == gap);
        bus_rdata  = (g == gap) ? seed + DW'(i) : 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if (fetch_done !== 1'b0 || mem_wen !== bus_rvalid) begin
          n_err++;
          $display("FAIL beat_ctl: beat %0d got done=%b wen=%b, required done=0 wen=%b",
                   i, fetch_done, mem_wen, bus_rvalid);
        end
        if (mem_wen === 1'b1) begin
          n_cmp++;
          if (exp_wr.size() == 0) begin
            n_err++;
            $display("FAIL wr_extra: got addr=%h data=%h, required no write", mem_waddr, mem_wdata);
          end else begin
            e = exp_wr.pop_front();
            if ({mem_waddr, mem_wdata} !== e) begin
              n_err++;
              $display("FAIL wr_data: got addr=%h data=%h, required addr=%h data=%h",
                       mem_waddr, mem_wdata, e[DW+TW+BW-1:DW], e[DW-1:0]);
            end
          end
        end
        if (hold) begin
          n_cmp++;
          if (fetch_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL busy_gnt_data: got fetch_gnt=%b, required 0", fetch_gnt);
          end
        end
        tick();
      end
    end
    bus_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fetch_done !== 1'b1 || exp_done.size() == 0) begin
      n_err++;
      $display("FAIL fill_done: got fetch_done=%b pending=%0d, required 1 / >0", fetch_done, exp_done.size());
    end else begin
      n_cmp++;
      if (done_tag !== exp_done[0]) begin
        n_err++;
        $display("FAIL fill_done_tag: got %h, required %h", done_tag, exp_done[0]);
      end
      void'(exp_done.pop_front());
    end
    if (hold) begin
      n_cmp++;
      if (fetch_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL busy_gnt_done: got fetch_gnt=%b, required 0", fetch_gnt);
      end
    end
    tick();
    if (tag != tag) ;
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    n_cmp++;
    if (exp_wr.size() != 0 || exp_done.size() != 0 || fetch_done !== 1'b0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: got pending wr=%0d done=%0d fetch_done=%b bus_req=%b, required 0/0/0/0",
               name, exp_wr.size(), exp_done.size(), fetch_done, bus_req);
    end
    tick();
  endtask

  task automatic test_fill_basic();
    issue_fill(2'd2, 32'h0000_1234, 32'd0);
    tick();
    idle_inputs();
    run_fill(2'd2, 32'h0000_1234, 32'd0, 3, 0, 1'b0);
    check_drained("fill_basic");
  endtask

  task automatic test_inval();
    exp_done.push_back(2'd1);
    fetch_req = 1'b1; fetch_cmd = CMD_INVAL; fetch_tag = 2'd1; fetch_addr = 32'h0000_0400;
    @(negedge clk);
    n_cmp++;
    if (fetch_gnt !== 1'b1 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL inval_gnt: got gnt=%b bus_req=%b, required 1 / 0", fetch_gnt, bus_req);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (fetch_done !== 1'b1 || bus_req !== 1'b0 || done_tag !== exp_done[0]) begin
      n_err++;
      $display("FAIL inval_done: got done=%b tag=%h bus_req=%b, required 1 / %h / 0",
               fetch_done, done_tag, bus_req, exp_done[0]);
    end
    void'(exp_done.pop_front());
    tick();
    check_drained("inval");
  endtask

  task automatic test_gap();
    issue_fill(2'd1, 32'h0ABC_DEF7, 32'h0000_0100);
    tick();
    idle_inputs();
    run_fill(2'd1, 32'h0ABC_DEF7, 32'h0000_0100, 0, 2, 1'b0);
    check_drained("gap");
  endtask

  task automatic test_back_to_back();
    issue_fill(2'd0, 32'h2000_0040, 32'hA000_0000);
    tick();
    fetch_req = 1'b1; fetch_cmd = CMD_FILL; fetch_tag = 2'd3; fetch_addr = 32'h0000_7F3F;
    run_fill(2'd0, 32'h2000_0040, 32'hA000_0000, 1, 0, 1'b1);
    issue_fill(2'd3, 32'h0000_7F3F, 32'hB000_0000);
    tick();
    idle_inputs();
    run_fill(2'd3, 32'h0000_7F3F, 32'hB000_0000, 2, 1, 1'b0);
    check_drained("back_to_back");
  endtask

  task automatic test_reset_midfill();
    wr_t e;
    issue_fill(2'd2, 32'h0000_0500, 32'h0000_0050);
    tick();
    idle_inputs();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      bus_rvalid = 1'b1; bus_rdata = 32'h0000_0050 + DW'(i);
      @(negedge clk);
      n_cmp++;
      e = exp_wr.pop_front();
      if (mem_wen !== 1'b1 || {mem_waddr, mem_wdata} !== e) begin
        n_err++;
        $display("FAIL midfill_wr: beat %0d got wen=%b addr=%h data=%h, required 1 / %h / %h",
                 i, mem_wen, mem_waddr, mem_wdata, e[DW+TW+BW-1:DW], e[DW-1:0]);
      end
      tick();
    end
    rst = 1'b1; bus_rdata = 32'h0000_0055;
    @(negedge clk);
    n_cmp++;
    if ({fetch_gnt, fetch_done, done_tag, bus_req, bus_addr, mem_wen, mem_waddr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL midfill_rst_outputs: got done=%b breq=%b wen=%b waddr=%h wdata=%h, required all 0",
               fetch_done, bus_req, mem_wen, mem_waddr, mem_wdata);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({fetch_done, bus_req, mem_wen, fetch_gnt} !== 4'b0) begin
        n_err++;
        $display("FAIL midfill_stray: got done=%b breq=%b wen=%b gnt=%b, required 0000",
                 fetch_done, bus_req, mem_wen, fetch_gnt);
      end
      tick();
    end
    idle_inputs();
    exp_wr.delete();
    exp_done.delete();
    issue_fill(2'd3, 32'hFFFF_FFFF, 32'h0000_0007);
    tick();
    idle_inputs();
    run_fill(2'd3, 32'hFFFF_FFFF, 32'h0000_0007, 1, 0, 1'b0);
    check_drained("after_reset");
  endtask

  task automatic test_nop();
    for (int k = 0; k < 2; k++) begin
      fetch_req = 1'b1; fetch_cmd = (k == 0) ? CMD_NOP : CMD_RSVD; fetch_tag = 2'd2;
      bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0000 + DW'(k);
      @(negedge clk);
      n_cmp++;
      if (fetch_gnt !== 1'b1 || mem_wen !== 1'b0 || fetch_done !== 1'b0) begin
        n_err++;
        $display("FAIL nop_gnt: cmd %0d got gnt=%b wen=%b done=%b, required 1/0/0", k, fetch_gnt, mem_wen, fetch_done);
      end
      tick();
      fetch_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({fetch_gnt, fetch_done, mem_wen, bus_req} !== 4'b0) begin
          n_err++;
          $display("FAIL nop_quiet: cmd %0d got gnt=%b done=%b wen=%b breq=%b, required 0000",
                   k, fetch_gnt, fetch_done, mem_wen, bus_req);
        end
        tick();
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_inval();
    test_fill_basic();
    test_gap();
    test_back_to_back();
    test_reset_midfill();
    test_nop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_engine.md
FETCH_ENGINE -- requirements
Module: fetch_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, bus and line-buffer data width.
REQ-003 Parameter LIST_DEPTH, default 4, number of line-buffer slots; TW = $clog2(LIST_DEPTH).
REQ-004 Parameter LIST_WIDTH, default 32, words per line; BW = $clog2(LIST_WIDTH).
REQ-005 The block shall have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 fetch_req  in  1  requester holds high until fetch_gnt.
REQ-009 fetch_cmd  in  2  operation: 00 NOP, 01 FILL, 10 INVAL, 11 reserved.
REQ-010 fetch_tag  in  TW  destination slot.
REQ-011 fetch_addr  in  ADDR_WIDTH  word address inside the target line.
REQ-012 fetch_gnt  out  1  one-cycle pulse: request accepted.
REQ-013 fetch_done  out  1  one-cycle pulse: slot filled or invalidated.
REQ-014 done_tag  out  TW  slot completed; valid while fetch_done is high.
REQ-015 bus_req / bus_addr  out  1 / ADDR_WIDTH  burst read request and line base address.
REQ-016 bus_gnt  in  1  bus accepts the burst.
REQ-017 bus_rdata / bus_rvalid  in  DATA_WIDTH / 1  returned beat and its qualifier.
REQ-018 mem_wen / mem_waddr / mem_wdata  out  1 / TW+BW / DATA_WIDTH  line-buffer write port.

Function
REQ-019 The FSM shall have the states IDLE, REQ, DATA and DONE, with at most one fetch outstanding at a time.
REQ-020 In IDLE with fetch_req=1 and cmd FILL, fetch_gnt shall be 1 in that cycle; tag and line base (fetch_addr with its low BW bits zeroed) are latched, and the next state is REQ.
REQ-021 In IDLE with fetch_req=1 and cmd INVAL, fetch_gnt shall be 1, the tag is latched, and the next state is DONE with no bus activity.
REQ-022 In IDLE with fetch_req=1 and cmd NOP or reserved, fetch_gnt shall pulse and the state shall stay IDLE, with no fetch_done.
REQ-023 fetch_gnt shall be 0 in every state other than IDLE.
REQ-024 In REQ, bus_req shall be 1 with bus_addr equal to the latched base; on bus_gnt=1, go to DATA and clear the beat counter.
REQ-025 In DATA, each bus_rvalid cycle shall drive mem_wen=1, mem_waddr={tag,beat} and mem_wdata=bus_rdata combinationally, then increment beat.
REQ-026 The beat at beat==LIST_WIDTH-1 shall be the last one and shall move the FSM to DATA→DONE; the counter wraps to 0.
REQ-027 Cycles in DATA with bus_rvalid=0 shall stall the FSM with no write; gaps are unbounded.
REQ-028 bus_rvalid outside DATA shall be ignored, with no mem_wen.
REQ-029 In DONE, fetch_done=1 and done_tag=latched tag for exactly one cycle, then the FSM returns to IDLE.
REQ-030 A request held in the cycle after DONE shall be granted in IDLE.
REQ-031 FILL latency from gnt shall be 1 cycle to bus_req, plus the bus grant wait, plus LIST_WIDTH beats, plus 1 DONE cycle; INVAL latency shall be fetch_done in the cycle after gnt.

Reset
REQ-032 While rst=1, the state shall be IDLE, the beat counter and latched tag/base 0, and all outputs (fetch_gnt, fetch_done, done_tag, bus_req, bus_addr, mem_wen, mem_waddr, mem_wdata) 0.
REQ-033 Reset during REQ or DATA shall abandon the fetch with no fetch_done; beats arriving after reset are dropped per REQ-028.

Structure
REQ-034 A shared package fetch_pkg shall hold the fetch_cmd enum (NOP, FILL, INVAL, RSVD) and the FSM state enum.
REQ-035 No sub-module is required; the beat counter and FSM shall be coded inline in fetch_engine.

Verification
REQ-036 FILL, tag 2, addr 0x0000_1234, bus_gnt after 3 cycles, 32 back-to-back beats of data i -> bus_addr 0x0000_1220; mem_waddr 0x40..0x5F get 0..31; one fetch_done with done_tag 2.
REQ-037 INVAL, tag 1 -> fetch_gnt in cycle 0; fetch_done with done_tag 1 in cycle 1; bus_req stays 0.
REQ-038 FILL with bus_rvalid every third cycle -> exactly 32 writes in order; fetch_done after the 32nd beat only.
REQ-039 Second FILL held during an active fetch -> no fetch_gnt until the cycle after fetch_done; the second fetch then completes normally.
REQ-040 rst pulsed after beat 10 of a FILL, followed by stray rvalids -> no mem_wen, no fetch_done, all outputs 0; the next FILL works.
REQ-041 NOP request and stray bus_rvalid in IDLE -> gnt pulse only; no writes and no fetch_done.
